// File: rtl/fp16_pkg.sv
// FP16 format constants, operand classes and status-flag bit positions
// shared by the FP16 multiply post-processing pipeline.
package fp16_pkg;
   localparam int          FP16_BIAS = 15;
   localparam logic [15:0] FP16_QNAN = 16'h7E00;
   localparam logic [15:0] FP16_INF  = 16'h7C00;

   typedef enum logic [1:0] {NORM, ZERO, INF, NAN} fp16_class_t;

   // Positions inside the 4-bit flag word {invalid, overflow, underflow, inexact}
   localparam int FLAG_INEXACT   = 0;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_INVALID   = 3;

   // Subnormal inputs are classed as zero (flush-to-zero on input).
   function automatic fp16_class_t fp16_classify(input logic [15:0] v);
      fp16_class_t c;
      if (v[14:10] == 5'd0)
         c = ZERO;
      else if (v[14:10] == 5'h1F)
         c = (v[9:0] == 10'd0) ? INF : NAN;
      else
         c = NORM;
      return c;
   endfunction
endpackage

// File: rtl/fp16_norm_round.sv
// Combinational normalize / round / range / special-case datapath.
// Build with FP_MUL_RNE_EN for round-to-nearest-even, otherwise truncation.
module fp16_norm_round
   import fp16_pkg::*;
(
   input  logic              sign,
   input  logic signed [6:0] exp_sum,
   input  fp16_class_t       class_a,
   input  fp16_class_t       class_b,
   input  logic [21:0]       p,
   output logic [15:0]       result,
   output logic [3:0]        flags
);
   logic [9:0]        mant_n;
   logic [9:0]        mant_r;
   logic              carry;
   logic              round_up;
   logic              lost;
   logic signed [6:0] exp_n;
   logic signed [6:0] exp_r;
   logic              any_nan;
   logic              any_inf;
   logic              any_zero;

   assign mant_n = p[21] ? p[20:11] : p[19:10];
   assign exp_n  = p[21] ? exp_sum + 7'sd1 : exp_sum;

`ifdef FP_MUL_RNE_EN
   logic guard;
   logic sticky;
   assign guard    = p[21] ? p[10] : p[9];
   assign sticky   = p[21] ? |p[9:0] : |p[8:0];
   assign round_up = guard & (sticky | mant_n[0]);
   assign lost     = guard | sticky;
`else
   assign round_up = 1'b0;
   assign lost     = p[21] ? |p[10:0] : |p[9:0];
`endif

   // A carry out of the fraction leaves mant_r at zero and bumps the exponent.
   assign {carry, mant_r} = {1'b0, mant_n} + {10'd0, round_up};
   assign exp_r = carry ? exp_n + 7'sd1 : exp_n;

   assign any_nan  = (class_a == NAN)  || (class_b == NAN);
   assign any_inf  = (class_a == INF)  || (class_b == INF);
   assign any_zero = (class_a == ZERO) || (class_b == ZERO);

   always_comb begin
      result = {sign, exp_r[4:0], mant_r};
      flags  = 4'd0;
      flags[FLAG_INEXACT] = lost;
      if (exp_r >= 7'sd31) begin
         result = FP16_INF | {sign, 15'd0};
         flags[FLAG_OVERFLOW] = 1'b1;
         flags[FLAG_INEXACT]  = 1'b1;
      end else if (exp_r <= 7'sd0) begin
         result = {sign, 15'd0};
         flags[FLAG_UNDERFLOW] = 1'b1;
         flags[FLAG_INEXACT]   = 1'b1;
      end
      // Special operands override whatever the range logic produced.
      if (any_nan || (any_inf && any_zero)) begin
         result = FP16_QNAN;
         flags  = 4'd0;
         flags[FLAG_INVALID] = 1'b1;
      end else if (any_inf) begin
         result = FP16_INF | {sign, 15'd0};
         flags  = 4'd0;
      end else if (any_zero) begin
         result = {sign, 15'd0};
         flags  = 4'd0;
      end
   end
endmodule

// File: rtl/fp16_mul_post.sv
// FP16 multiply post-processing pipeline: operand decode, normalize/round,
// registered result with valid/ready back-pressure. Rounding mode: FP_MUL_RNE_EN.
module fp16_mul_post
   import fp16_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   input  logic [23:0] product,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_result,
   output logic [3:0]  out_flags
);
   logic              s1_valid;
   logic              s1_sign;
   logic signed [6:0] s1_exp_sum;
   fp16_class_t       s1_class_a;
   fp16_class_t       s1_class_b;
   logic [21:0]       s1_p;

   logic              s2_valid;
   logic              s2_sign;
   logic signed [6:0] s2_exp_sum;
   fp16_class_t       s2_class_a;
   fp16_class_t       s2_class_b;
   logic [21:0]       s2_p;

   logic              out_load;
   logic              s2_load;
   logic              s1_load;
   logic [15:0]       nr_result;
   logic [3:0]        nr_flags;
   logic              unused_product_hi;

   assign unused_product_hi = ^product[23:22];

   // Handshake: a beat moves on any edge where valid && ready. Each register
   // tier loads when it is empty or the tier after it is loading, so a full
   // pipeline still advances every cycle while out_ready is high.
   assign out_load = !out_valid || out_ready;
   assign s2_load  = !s2_valid || out_load;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

   fp16_norm_round u_norm_round (
      .sign    (s2_sign),
      .exp_sum (s2_exp_sum),
      .class_a (s2_class_a),
      .class_b (s2_class_b),
      .p       (s2_p),
      .result  (nr_result),
      .flags   (nr_flags)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_sign    <= 1'b0;
         s1_exp_sum <= '0;
         s1_class_a <= ZERO;
         s1_class_b <= ZERO;
         s1_p       <= '0;
         s2_valid   <= 1'b0;
         s2_sign    <= 1'b0;
         s2_exp_sum <= '0;
         s2_class_a <= ZERO;
         s2_class_b <= ZERO;
         s2_p       <= '0;
         out_valid  <= 1'b0;
         out_result <= 16'h0000;
         out_flags  <= 4'd0;
      end else begin
         if (out_load) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
               out_result <= nr_result;
               out_flags  <= nr_flags;
            end
         end
         if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_sign    <= s1_sign;
               s2_exp_sum <= s1_exp_sum;
               s2_class_a <= s1_class_a;
               s2_class_b <= s1_class_b;
               s2_p       <= s1_p;
            end
         end
         if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_sign    <= op_a[15] ^ op_b[15];
               s1_exp_sum <= $signed({2'b00, op_a[14:10]} + {2'b00, op_b[14:10]}
                                     - 7'(FP16_BIAS));
               s1_class_a <= fp16_classify(op_a);
               s1_class_b <= fp16_classify(op_b);
               s1_p       <= product[21:0];
            end
         end
      end
   end
endmodule
